// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver feeding a receive FIFO, read through a
//               data register (pops) and a status register (clears flags).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        rstrb,
    input  logic        sel_dat,
    input  logic        sel_cntl,
    output logic [31:0] rdata,
    output logic        brk
);

    localparam int c_clks_per_bit = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_cnt_w        = $clog2(c_clks_per_bit);
    localparam int c_ptr_w        = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_half_reload = c_cnt_w'(c_clks_per_bit / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_reload = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_ptr_w:0]   c_depth       = (c_ptr_w + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_stop      = 3'd3;
    localparam logic [2:0] c_st_wait_idle = 3'd4;

    logic               r_rxd_meta;
    logic               r_rxd_s;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               w_push;
    logic               w_frame_set;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_overrun;
    logic               r_frame_err;
    logic               r_brk;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_overrun_set;
    logic               w_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // The counter reloads on every state entry; a sample is taken when it hits zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!r_rxd_s) begin
                    w_state_nxt = c_st_start;
                    w_cnt_nxt   = c_half_reload;
                end
            end
            c_st_start: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_rxd_s) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_state_nxt = c_st_data;
                    w_cnt_nxt   = c_full_reload;
                    w_bit_nxt   = 3'd0;
                end
            end
            c_st_data: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    w_shift_nxt = {r_rxd_s, r_shift[7:1]};
                    w_cnt_nxt   = c_full_reload;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_st_stop;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            c_st_stop: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_rxd_s) begin
                    w_push      = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_frame_set = 1'b1;
                    w_state_nxt = c_st_wait_idle;
                end
            end
            c_st_wait_idle: begin
                if (r_rxd_s) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_depth);
    assign w_pop         = rstrb & sel_dat & ~w_empty;
    assign w_wr_en       = w_push & (~w_full | w_pop);
    assign w_overrun_set = w_push & w_full & ~w_pop;
    assign w_clear       = rstrb & sel_cntl;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // A flag being set in the same cycle as a clear stays set.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_clear) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (w_clear) begin
                r_frame_err <= 1'b0;
            end
            r_brk <= w_push && (r_shift == 8'h03);
        end
    end

    assign brk = r_brk;

    always_comb begin
        rdata = 32'h0;
        if (sel_dat) begin
            if (!w_empty) begin
                rdata = {24'h0, r_mem[r_rd_ptr]};
            end
        end else if (sel_cntl) begin
            rdata = {16'h0, 8'(r_count), 5'b0, r_frame_err, r_overrun, ~w_empty};
        end
    end

endmodule
`default_nettype wire
